proc_step_ctrl: RTL and testbench



---
 rtl/proc_step_pkg.sv | 12 +
 rtl/proc_step_ctrl_if.sv | 40 ++++
 rtl/sync_rise_det.sv | 33 +++
 rtl/proc_step_ctrl.sv | 162 ++++++++++++++++
 tb/tb_proc_step_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/proc_step_pkg.sv
// Shared state encoding for the processor step controller.
// The 2-bit values are visible on the state output and must stay fixed.
package proc_step_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_RUN       = 2'd1;
   localparam logic [1:0] ST_STEP_WAIT = 2'd2;
   localparam logic [1:0] ST_HALTED    = 2'd3;

endpackage

// File: rtl/proc_step_ctrl_if.sv
// Control/status bundle between the board-side driver (master) and proc_step_ctrl (slave).
// Breakpoint signals exist only when PROC_STEP_BREAK_EN is defined.
interface proc_step_ctrl_if
   import proc_step_pkg::*;
#(
   parameter int CNT_W = 16
) ();

   logic             slow_clk;
   logic             run_mode;
   logic             step_btn;
   logic             halt_req;
   logic             clear_halt;
   logic             proc_en;
   state_t           state;
   logic [CNT_W-1:0] cycle_count;
`ifdef PROC_STEP_BREAK_EN
   logic [CNT_W-1:0] break_at;
   logic             break_hit;
`endif

   modport master (
      output slow_clk, output run_mode, output step_btn,
      output halt_req, output clear_halt,
      input  proc_en, input state, input cycle_count
`ifdef PROC_STEP_BREAK_EN
      , output break_at, input break_hit
`endif
   );

   modport slave (
      input  slow_clk, input run_mode, input step_btn,
      input  halt_req, input clear_halt,
      output proc_en, output state, output cycle_count
`ifdef PROC_STEP_BREAK_EN
      , input break_at, output break_hit
`endif
   );

endinterface

// File: rtl/sync_rise_det.sv
// Multi-flop synchronizer for an asynchronous level, plus a registered
// one-cycle pulse on its synchronized 0->1 transition.
module sync_rise_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clkin,
   input  logic reset,
   input  logic din,
   output logic level,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_r;
   logic                   edge_r;
   logic                   rise_r;

   // synchronizer chain, previous-value flop and registered rise pulse
   always_ff @(posedge clkin) begin
      if (reset) begin
         sync_r <= {SYNC_STAGES{1'b0}};
         edge_r <= 1'b0;
         rise_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], din};
         edge_r <= sync_r[SYNC_STAGES-1];
         rise_r <= sync_r[SYNC_STAGES-1] & ~edge_r;
      end
   end

   assign level = sync_r[SYNC_STAGES-1];
   assign rise  = rise_r;

endmodule

// File: rtl/proc_step_ctrl.sv
// Generates processor clock-enable pulses from the sampled slow divider clock
// in free-run, single-step and halted modes. Optional breakpoint: PROC_STEP_BREAK_EN.
module proc_step_ctrl
   import proc_step_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DEB_CYCLES  = 8,
   parameter int CNT_W       = 16
) (
   input  logic           clkin,
   input  logic           reset,
   proc_step_ctrl_if.slave bus
);

   localparam int             DEB_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
   localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             tick_s;
   logic             slow_level_unused_s;
   logic             step_lvl_s;
   logic             step_rise_unused_s;
   logic             step_req_s;
   logic             deb_r;
   logic             deb_prev_r;
   logic [DEB_W-1:0] deb_cnt_r;
   state_t           state_r;
   state_t           state_nxt_s;
   logic             pulse_s;
   logic             proc_en_r;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             cnt_inc_s;
   logic             brk_s;

   sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_slow_sync (
      .clkin (clkin),
      .reset (reset),
      .din   (bus.slow_clk),
      .level (slow_level_unused_s),
      .rise  (tick_s)
   );

   sync_rise_det #(.SYNC_STAGES(SYNC_STAGES)) u_btn_sync (
      .clkin (clkin),
      .reset (reset),
      .din   (bus.step_btn),
      .level (step_lvl_s),
      .rise  (step_rise_unused_s)
   );

   // level flips only after DEB_CYCLES consecutive samples disagree with it
   always_ff @(posedge clkin) begin
      if (reset) begin
         deb_r      <= 1'b0;
         deb_prev_r <= 1'b0;
         deb_cnt_r  <= {DEB_W{1'b0}};
      end else begin
         deb_prev_r <= deb_r;
         if (step_lvl_s != deb_r) begin
            if (deb_cnt_r == DEB_LAST) begin
               deb_r     <= step_lvl_s;
               deb_cnt_r <= {DEB_W{1'b0}};
            end else begin
               deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
         end else begin
            deb_cnt_r <= {DEB_W{1'b0}};
         end
      end
   end

   assign step_req_s = deb_r & ~deb_prev_r;

   // halt_req outranks mode changes, which outrank tick/step
   always_comb begin
      state_nxt_s = state_r;
      pulse_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (bus.halt_req)      state_nxt_s = ST_HALTED;
            else if (bus.run_mode) state_nxt_s = ST_RUN;
            else if (step_req_s)   state_nxt_s = ST_STEP_WAIT;
            else                   state_nxt_s = ST_IDLE;
         end
         ST_RUN: begin
            if (bus.halt_req)       state_nxt_s = ST_HALTED;
            else if (!bus.run_mode) state_nxt_s = ST_IDLE;
            else if (tick_s)        pulse_s     = 1'b1;
            else                    state_nxt_s = ST_RUN;
         end
         ST_STEP_WAIT: begin
            if (bus.halt_req) begin
               state_nxt_s = ST_HALTED;
            end else if (tick_s) begin
               pulse_s     = 1'b1;
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_STEP_WAIT;
            end
         end
         ST_HALTED: begin
            if (bus.clear_halt && !bus.halt_req) state_nxt_s = ST_IDLE;
            else                                 state_nxt_s = ST_HALTED;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   assign cnt_inc_s = pulse_s & (cnt_r != CNT_MAX);
   assign cnt_nxt_s = cnt_r + CNT_ONE;

`ifdef PROC_STEP_BREAK_EN
   logic break_hit_r;

   // a breakpoint fires on the same edge the counter reaches break_at
   assign brk_s = cnt_inc_s & (bus.break_at != {CNT_W{1'b0}}) & (cnt_nxt_s == bus.break_at);

   // sticky breakpoint flag
   always_ff @(posedge clkin) begin
      if (reset) begin
         break_hit_r <= 1'b0;
      end else if (brk_s) begin
         break_hit_r <= 1'b1;
      end else if (bus.clear_halt) begin
         break_hit_r <= 1'b0;
      end else begin
         break_hit_r <= break_hit_r;
      end
   end

   assign bus.break_hit = break_hit_r;
`else
   assign brk_s = 1'b0;
`endif

   // registered state, enable pulse and saturating executed-cycle counter
   always_ff @(posedge clkin) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         proc_en_r <= 1'b0;
         cnt_r     <= {CNT_W{1'b0}};
      end else begin
         state_r   <= brk_s ? ST_HALTED : state_nxt_s;
         proc_en_r <= pulse_s;
         if (cnt_inc_s) begin
            cnt_r <= cnt_nxt_s;
         end else begin
            cnt_r <= cnt_r;
         end
      end
   end

   assign bus.proc_en     = proc_en_r;
   assign bus.state       = state_r;
   assign bus.cycle_count = cnt_r;

endmodule

// File: tb/tb_proc_step_ctrl.sv
// Randomized bench for proc_step_ctrl, checked every cycle against a
// history-based model of the timing and mode rules. CNT_W=4 to reach saturation.
module tb_proc_step_ctrl;
   import proc_step_pkg::*;

   localparam int CNT_W   = 4;
   localparam int DEB     = 8;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic clkin = 1'b0;
   logic reset = 1'b1;

   proc_step_ctrl_if #(.CNT_W(CNT_W)) bus ();

   proc_step_ctrl #(.SYNC_STAGES(2), .DEB_CYCLES(DEB), .CNT_W(CNT_W)) dut (
      .clkin (clkin),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clkin = ~clkin;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc_n  = 0;

   // model state: histories hold samples taken at the last few edges, [0] = newest
   bit m_sc [0:4];
   bit m_bt [0:DEB+1];
   int m_st, m_cnt;
   bit m_pe, m_lvl, m_pend, m_bh;

   int  sc_half = 0, sc_cnt = 0, first_rise = -1;
   bit  sc_rand = 1'b0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc_n);
      end
   endtask

   task automatic model_edge();
      bit tick, sreq, pulse, hit, all_diff;
      int ns;
      if (reset) begin
         foreach (m_sc[k]) m_sc[k] = 1'b0;
         foreach (m_bt[k]) m_bt[k] = 1'b0;
         m_st = 0; m_cnt = 0; m_pe = 0; m_lvl = 0; m_pend = 0; m_bh = 0;
         return;
      end
      for (int k = 4; k > 0; k--) m_sc[k] = m_sc[k-1];
      m_sc[0] = bus.slow_clk;
      for (int k = DEB + 1; k > 0; k--) m_bt[k] = m_bt[k-1];
      m_bt[0] = bus.step_btn;
      // a slow_clk rise sampled at edge n yields proc_en at edge n+3
      tick  = m_sc[3] && !m_sc[4];
      sreq  = m_pend;
      pulse = 1'b0;
      hit   = 1'b0;
      ns    = m_st;
      case (m_st)
         0: if (bus.halt_req) ns = 3; else if (bus.run_mode) ns = 1; else if (sreq) ns = 2;
         1: if (bus.halt_req) ns = 3; else if (!bus.run_mode) ns = 0; else if (tick) pulse = 1'b1;
         2: if (bus.halt_req) ns = 3; else if (tick) begin pulse = 1'b1; ns = 0; end
         default: if (bus.clear_halt && !bus.halt_req) ns = 0;
      endcase
      m_pe = pulse;
      if (pulse && m_cnt < CNT_MAX) begin
         m_cnt++;
`ifdef PROC_STEP_BREAK_EN
         if (bus.break_at != 0 && m_cnt == int'(bus.break_at)) begin
            ns  = 3;
            hit = 1'b1;
         end
`endif
      end
      if (hit) m_bh = 1'b1;
      else if (bus.clear_halt) m_bh = 1'b0;
      m_st = ns;
      all_diff = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) if (m_bt[k] == m_lvl) all_diff = 1'b0;
      if (all_diff) m_lvl = !m_lvl;
      m_pend = all_diff && m_lvl;
   endtask

   task automatic cyc();
      cyc_n++;
      @(posedge clkin);
      model_edge();
      @(negedge clkin);
      chk_eq("proc_en", {31'd0, bus.proc_en}, {31'd0, m_pe});
      chk_eq("state", {30'd0, bus.state}, m_st);
      chk_eq("cycle_count", {28'd0, bus.cycle_count}, m_cnt);
`ifdef PROC_STEP_BREAK_EN
      chk_eq("break_hit", {31'd0, bus.break_hit}, {31'd0, m_bh});
`endif
      if (sc_half != 0) begin
         sc_cnt++;
         if (sc_cnt >= sc_half) begin
            sc_cnt = 0;
            bus.slow_clk = ~bus.slow_clk;
            if (bus.slow_clk && first_rise < 0) first_rise = cyc_n;
            if (sc_rand) sc_half = $urandom_range(2, 15);
         end
      end
   endtask

   initial begin
      int first_pe, second_pe, pe_cnt, btn_left;
      bit found;
      bus.slow_clk = 1'b0; bus.run_mode = 1'b0; bus.step_btn = 1'b0;
      bus.halt_req = 1'b0; bus.clear_halt = 1'b0;
`ifdef PROC_STEP_BREAK_EN
      bus.break_at = '0;
`endif
      @(negedge clkin);
      repeat (3) cyc();
      chk_eq("reset_state", {30'd0, bus.state}, 0);
      reset = 1'b0;

      // free-run with slow_clk period 22: first latency 4, spacing 22
      bus.run_mode = 1'b1;
      sc_half = 11; sc_cnt = 0; first_rise = -1;
      first_pe = -1; second_pe = -1;
      repeat (100) begin
         cyc();
         if (bus.proc_en) begin
            if (first_pe < 0) first_pe = cyc_n;
            else if (second_pe < 0) second_pe = cyc_n;
         end
      end
      chk_eq("first_latency", first_pe - first_rise, 4);
      chk_eq("pulse_spacing", second_pe - first_pe, 22);

      // single step: long press gives one pulse, 3-cycle glitch gives none
      bus.run_mode = 1'b0;
      repeat (5) cyc();
      pe_cnt = 0;
      bus.step_btn = 1'b1;
      repeat (20) begin cyc(); pe_cnt += bus.proc_en; end
      bus.step_btn = 1'b0;
      repeat (40) begin cyc(); pe_cnt += bus.proc_en; end
      chk_eq("step_pulses", pe_cnt, 1);
      chk_eq("step_state", {30'd0, bus.state}, 0);
      pe_cnt = 0;
      bus.step_btn = 1'b1;
      repeat (3) cyc();
      bus.step_btn = 1'b0;
      repeat (40) begin cyc(); pe_cnt += bus.proc_en; end
      chk_eq("glitch_pulses", pe_cnt, 0);

      // halt_req coincident with tick in RUN
      bus.run_mode = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 60 && !found; i++) begin
         if (m_st == 1 && m_sc[2] && !m_sc[3]) found = 1'b1;
         else cyc();
      end
      chk_eq("tick_found", {31'd0, found}, 1);
      bus.halt_req = 1'b1;
      cyc();
      bus.halt_req = 1'b0;
      chk_eq("halt_no_pulse", {31'd0, bus.proc_en}, 0);
      chk_eq("halt_state", {30'd0, bus.state}, 3);
      pe_cnt = 0;
      repeat (50) begin cyc(); pe_cnt += bus.proc_en; end
      chk_eq("halted_pulses", pe_cnt, 0);
      bus.halt_req = 1'b1; bus.clear_halt = 1'b1;
      cyc();
      bus.halt_req = 1'b0; bus.clear_halt = 1'b0;
      chk_eq("clear_vs_halt", {30'd0, bus.state}, 3);
      bus.clear_halt = 1'b1;
      cyc();
      bus.clear_halt = 1'b0;
      chk_eq("clear_to_idle", {30'd0, bus.state}, 0);
      cyc();
      chk_eq("idle_to_run", {30'd0, bus.state}, 1);

      // randomized mix of modes, halts, button presses and resets
      sc_rand = 1'b1;
      btn_left = 0;
      repeat (1500) begin
         bus.halt_req   = ($urandom_range(0, 59) == 0);
         bus.clear_halt = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 149) == 0) bus.run_mode = ~bus.run_mode;
         reset = ($urandom_range(0, 399) == 0);
`ifdef PROC_STEP_BREAK_EN
         if ($urandom_range(0, 199) == 0) bus.break_at = CNT_W'($urandom_range(0, CNT_MAX));
`endif
         if (btn_left > 0) begin
            bus.step_btn = 1'b1;
            btn_left--;
         end else begin
            bus.step_btn = 1'b0;
            if ($urandom_range(0, 39) == 0) btn_left = $urandom_range(1, 20);
         end
         cyc();
      end
      bus.halt_req = 1'b0; bus.clear_halt = 1'b0; bus.step_btn = 1'b0;
      sc_rand = 1'b0;

      // saturation at 2^CNT_W-1
`ifdef PROC_STEP_BREAK_EN
      bus.break_at = '0;
`endif
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      chk_eq("post_reset_count", {28'd0, bus.cycle_count}, 0);
      bus.run_mode = 1'b1; sc_half = 4; sc_cnt = 0;
      repeat (200) cyc();
      chk_eq("saturated", {28'd0, bus.cycle_count}, CNT_MAX);

`ifdef PROC_STEP_BREAK_EN
      reset = 1'b1;
      repeat (2) cyc();
      reset = 1'b0;
      bus.break_at = CNT_W'(5);
      for (int i = 0; i < 100 && bus.state != ST_HALTED; i++) cyc();
      chk_eq("break_state", {30'd0, bus.state}, 3);
      chk_eq("break_count", {28'd0, bus.cycle_count}, 5);
      chk_eq("break_hit_set", {31'd0, bus.break_hit}, 1);
      bus.clear_halt = 1'b1;
      cyc();
      bus.clear_halt = 1'b0;
      chk_eq("break_hit_clr", {31'd0, bus.break_hit}, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
